// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: default widths, reset PC and the
// fetch control state encoding.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    StResetHold = 2'd0,
    StRun       = 2'd1,
    StStall     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer with push/pop/flush and occupancy output.
// Flush wins over push and pop; pop on empty is ignored.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != 2'd0);
    // A full buffer only accepts a push when the head leaves at the same edge.
    do_push  = push & ((count_q != 2'd2) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (!flush && do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a clocked-address RAM, tracks one read in flight
// and buffers returned words in a 2-entry FIFO for the decode stage.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-1:0]        pend_pc_q, pend_pc_d;
  logic                     pending_q, pending_d;
  logic                     issue, push, pop, room;
  logic [1:0]               count;
  logic [ADDR_W+DATA_W-1:0] fifo_wdata, fifo_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StResetHold;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StResetHold: state_d = StRun;
      StRun, StStall: begin
        if (!redirect_valid) state_d = issue ? StRun : StStall;
      end
      default: state_d = StResetHold;
    endcase
  end

  // Output / control logic
  always_comb begin
    // Occupancy plus the in-flight word must still fit once this read returns.
    room  = ({1'b0, count} + {2'b00, pending_q} + 3'd1)
            <= (3'd2 + {2'b00, instr_valid & instr_ready});
    issue = (state_q != StResetHold) & en & ~redirect_valid & room;
    push  = pending_q & ~redirect_valid;
    pop   = instr_valid & instr_ready & ~redirect_valid;
  end

  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pending_d = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d      = pc_q + ADDR_W'(1);
      pend_pc_d = pc_q;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pending_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pending_q <= pending_d;
    end
  end

  assign fifo_wdata = {pend_pc_q, mem_rdata};

  fetch_fifo #(
    .WIDTH(ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign mem_addr    = pc_q;
  assign instr_valid = (count != 2'd0);
  assign instr       = fifo_rdata[DATA_W-1:0];
  assign instr_pc    = fifo_rdata[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch against a clocked-address RAM holding word i = i.
// Stimulus queues expected {pc, instr} pairs; a negedge monitor checks each transfer.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic [3:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic [15:0] ram [16];
  logic [3:0]  ram_addr_q;
  logic [19:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  always @(posedge clk) ram_addr_q <= mem_addr;
  assign mem_rdata = ram[ram_addr_q];

  function automatic logic [19:0] mk(input int v);
    logic [15:0] w;
    w = 16'(v);
    return {w[3:0], w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the next posedge when valid & ready and no redirect.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer actual pc=%0h instr=%0h required none",
                 instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          errors++;
          $display("FAIL transfer actual pc=%0h instr=%0h required pc=%0h instr=%0h",
                   instr_pc, instr, e[19:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 16'(i);
    ram_addr_q     = '0;
    rst_n          = 1'b0;
    en             = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    #1;
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", 32'(instr), 32'd0);
    chk("reset_instr_pc", 32'(instr_pc), 32'd0);
    tick();
    tick();

    // Streaming from reset through the 15 -> 0 wrap, then up to 6
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(i));
    for (int i = 0; i <= 6; i++) exp_q.push_back(mk(i));
    rst_n = 1'b1;
    tick();
    chk("hold_edge1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("edge2_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("edge3_valid", 32'(instr_valid), 32'd1);
    chk("edge3_instr", 32'(instr), 32'd0);
    for (int k = 0; k < 19; k++) begin
      chk("stream_no_bubble", 32'(instr_valid), 32'd1);
      tick();
    end

    // Back-pressure with instr 3 at the head
    chk("bp_head", 32'(instr), 32'd3);
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_instr", 32'(instr), 32'd3);
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_mem_addr", 32'(mem_addr), 32'd5);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_resume_valid", 32'(instr_valid), 32'd1);
    end
    chk("bp_resume_head", 32'(instr), 32'd6);
    instr_ready = 1'b0;

    // Asynchronous reset between edges drops the buffered word 6
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_instr", 32'(instr), 32'd0);
    chk("dropped_left_in_queue", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick();
    tick();

    // Redirect to 10 while 4 is at the head and 5 is in flight
    foreach (exp_q[i]) exp_q.delete(i);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i));
    for (int i = 10; i <= 12; i++) exp_q.push_back(mk(i));
    instr_ready = 1'b1;
    rst_n       = 1'b1;
    repeat (7) tick();
    chk("redir_head_before", 32'(instr), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd10;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid_cleared", 32'(instr_valid), 32'd0);
    chk("redir_mem_addr", 32'(mem_addr), 32'd10);
    tick();
    chk("redir_issue_valid", 32'(instr_valid), 32'd0);
    chk("redir_issue_mem_addr", 32'(mem_addr), 32'd11);
    tick();
    chk("redir_target_valid", 32'(instr_valid), 32'd1);
    chk("redir_target_instr", 32'(instr), 32'd10);
    chk("redir_target_pc", 32'(instr_pc), 32'd10);

    // en=0 with 12 in flight: 12 still arrives, fetch address freezes at 13
    tick();
    en = 1'b0;
    tick();
    chk("en0_pending_delivered", 32'(instr), 32'd12);
    tick();
    chk("en0_drained", 32'(instr_valid), 32'd0);
    chk("en0_mem_addr", 32'(mem_addr), 32'd13);
    tick();
    tick();
    chk("en0_mem_addr_frozen", 32'(mem_addr), 32'd13);

    // Resume at the frozen address
    exp_q.push_back(mk(13));
    exp_q.push_back(mk(14));
    en = 1'b1;
    tick();
    chk("resume_mem_addr", 32'(mem_addr), 32'd14);
    tick();
    chk("resume_instr", 32'(instr), 32'd13);
    en = 1'b0;
    repeat (4) tick();
    chk("final_mem_addr", 32'(mem_addr), 32'd15);
    chk("final_valid", 32'(instr_valid), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the memory address and PC width (16 words).
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction word width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 en  input  1  SHALL be the run enable; issue of new reads only while high.
REQ-007 redirect_valid  input  1  SHALL be the branch/jump request, sampled each edge.
REQ-008 redirect_pc  input  ADDR_W  SHALL be the new fetch address when redirect_valid=1.
REQ-009 mem_addr  output  ADDR_W  SHALL be the read address to the RAM, equal to the fetch PC register (combinational from a register only).
REQ-010 mem_rdata  input  DATA_W  SHALL be the RAM read data, valid in the cycle after the edge that sampled mem_addr.
REQ-011 instr  output  DATA_W  SHALL be the instruction at the buffer head.
REQ-012 instr_pc  output  ADDR_W  SHALL be the address of instr.
REQ-013 instr_valid  output  1  SHALL flag a valid instr/instr_pc.
REQ-014 instr_ready  input  1  SHALL be the decode-stage accept; transfer occurs when instr_valid and instr_ready are both 1 at an edge.

Function
REQ-015 Read issue: at an edge with issue=1 the RAM latches mem_addr, pending<=1, pend_pc<=pc, pc<=pc+1 modulo 2^ADDR_W (15 -> 0).
REQ-016 issue SHALL be en & ~redirect_valid & (count + pending + 1 <= 2 + pop), where count = buffer occupancy (0..2) and pop = instr_valid & instr_ready.
REQ-017 At the edge after an issue, mem_rdata and pend_pc SHALL be written into a 2-entry FIFO unless discarded; pending clears unless a new issue occurs at the same edge.
REQ-018 Issue-edge to instr_valid latency SHALL be 2 edges; with en=1 and instr_ready=1 throughput SHALL be one instruction per cycle.
REQ-019 instr_valid SHALL equal (count != 0); instr/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-020 Push and pop at the same edge SHALL both take effect; FIFO SHALL never overflow (REQ-016 guarantees) and pop on empty SHALL be ignored.
REQ-021 Redirect: at an edge with redirect_valid=1, pc<=redirect_pc, FIFO SHALL be cleared, any pending read SHALL be discarded, no issue occurs; redirect overrides issue, push and pop.
REQ-022 First fetch of the redirect target SHALL issue at the next edge with en=1; first redirected instr_valid 2 edges after that.
REQ-023 en=0 SHALL stop new issues only; a pending read still completes into the FIFO and the FIFO still drains.
REQ-024 FSM states: RESET_HOLD (first edge after reset release, no issue), RUN (issue allowed per REQ-016), STALL (en=0 or FIFO-limited); RESET_HOLD->RUN unconditionally, RUN<->STALL on issue condition, any state stays put but applies REQ-021 on redirect.

Reset
REQ-025 While rst_n=0: pc=RESET_PC, pending=0, pend_pc=0, count=0, FIFO pointers=0, state=RESET_HOLD; hence mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-026 Reset asserted mid-operation SHALL drop all buffered and pending instructions immediately, without waiting for clk.

Structure
REQ-027 ADDR_W/DATA_W defaults, RESET_PC and the FSM state encoding SHALL live in the shared CPU package.
REQ-028 The 2-entry buffer SHALL be a sub-module fetch_fifo (parameterised width, push/pop/flush, count output).

Verification (RAM preloaded word i = i, clocked-address RAM model)
REQ-029 Reset release, en=1, instr_ready=1 -> instr_valid rises 3 edges after release, sequence instr=0,1,2,... with instr_pc=instr, one per cycle.
REQ-030 Run to PC 15 -> instr 15 followed directly by instr 0, no bubble.
REQ-031 instr_ready=0 for 5 cycles after instr 3 valid -> instr holds 3, mem_addr stops at 5, no loss; ready=1 -> 3,4,5,6 back-to-back.
REQ-032 redirect_valid=1, redirect_pc=10 while instr 4 valid and 5 in flight -> 4 and 5 never accepted; next valid instr=10, instr_pc=10, 2 edges after first issue of 10.
REQ-033 en=0 with one read pending -> that word delivered, mem_addr frozen; en=1 -> fetch resumes at frozen address.
REQ-034 rst_n low between edges mid-stream -> instr_valid=0 and mem_addr=0 immediately, before next clk edge.
